// File: rtl/morph_stream_filter.sv
`default_nettype none
// ============================================================================
// Module      : morph_stream_filter
// Description : Streaming 3x3 binary morphology (pass / erode / dilate / edge)
//               over a raster pixel stream. The pixel stream is buffered in two
//               IMG_WIDTH-deep line buffers. Neighbours outside the frame read
//               BORDER_VAL. Both sides use a valid/ready handshake.
// Optional    : `define MORPH_RANK_EN adds rank_k_i[3:0]. A non-zero rank
//               overrides op and gives out = (popcount(window) >= rank).
// Ports       : clk_i, rst_ni (async, active-low)
//               op_i[1:0]       00 pass, 01 erode, 10 dilate, 11 edge
//               in_valid_i / in_ready_o / in_pixel_i / in_sof_i   pixel sink
//               out_valid_o / out_ready_i / out_pixel_o            pixel source
//               out_sof_o / out_eof_o   first / last output of a frame
//               busy_o                  frame in progress
//               frame_err_o             one-cycle protocol-error pulse
// Revision    : 1.0 - initial release
// ============================================================================
module morph_stream_filter #(
    parameter int   IMG_WIDTH  = 256,
    parameter int   IMG_HEIGHT = 128,
    parameter logic BORDER_VAL = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] op_i,
`ifdef MORPH_RANK_EN
    input  logic [3:0] rank_k_i,
`endif
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic       in_pixel_i,
    input  logic       in_sof_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       out_pixel_o,
    output logic       out_sof_o,
    output logic       out_eof_o,
    output logic       busy_o,
    output logic       frame_err_o
);

    localparam int            CW       = $clog2(IMG_WIDTH);
    localparam int            RW       = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [1:0]    OP_PASS  = 2'b00;
    localparam logic [1:0]    OP_ERODE = 2'b01;
    localparam logic [1:0]    OP_DIL   = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
    logic [RW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
    logic [1:0]    op_q, op_d;
    // Window columns, bit 0 = row above centre, bit 1 = centre row, bit 2 = row below.
    logic [2:0]    cl_q, cl_d, cc_q, cc_d;
    logic          out_valid_q, out_valid_d, out_pixel_q, out_pixel_d;
    logic          out_sof_q, out_sof_d, out_eof_q, out_eof_d;
    logic          frame_err_q, frame_err_d;
`ifdef MORPH_RANK_EN
    logic [3:0]    rank_q, rank_d;
    logic [3:0]    w_pop;
`endif

    // Line buffers: lb0 holds the previous row, lb1 the row before that.
    logic          lb0_q [IMG_WIDTH];
    logic          lb1_q [IMG_WIDTH];

    logic          w_accept, w_sof_start, w_stray, w_abort, w_px_acc;
    logic          w_flush_step, w_adv, w_emit, w_pix, w_res;
    logic [CW-1:0] w_col;
    logic [2:0]    w_in_col, w_rmask;
    logic          w_lmask, w_cmask;
    logic [8:0]    w_win;

    always_comb begin
        in_ready_o = 1'b0;
        case (state_q)
            S_IDLE:        in_ready_o = 1'b1;
            S_FILL, S_RUN: in_ready_o = !out_valid_q || out_ready_i;
            default:       in_ready_o = 1'b0;
        endcase
    end

    assign w_accept    = in_valid_i && in_ready_o;
    assign w_sof_start = w_accept && in_sof_i;
    assign w_stray     = w_accept && !in_sof_i && (state_q == S_IDLE);
    assign w_abort     = w_sof_start && (state_q != S_IDLE);
    assign w_px_acc    = w_accept && !in_sof_i && (state_q != S_IDLE);
    // FLUSH emulates accepts of pixels below the frame until the last output
    // has been loaded; those pseudo pixels are masked as border anyway.
    assign w_flush_step = (state_q == S_FLUSH) && (!out_valid_q || out_ready_i)
                          && !(out_valid_q && out_eof_q);
    assign w_adv       = w_sof_start || w_px_acc || w_flush_step;
    assign w_emit      = (w_px_acc && (state_q == S_RUN)) || w_flush_step;
    assign w_pix       = (state_q == S_FLUSH) ? BORDER_VAL : in_pixel_i;
    // A frame-start pixel always lands in column 0, even when it aborts mid-row.
    assign w_col       = w_sof_start ? '0 : in_col_q;
    assign w_in_col    = {w_pix, lb0_q[w_col], lb1_q[w_col]};

    always_ff @(posedge clk_i) begin
        if (w_adv) begin
            lb1_q[w_col] <= lb0_q[w_col];
            lb0_q[w_col] <= w_pix;
        end
    end

    // The output being produced is centred on (out_row, out_col): cc_q is its
    // column, cl_q the column to the left and w_in_col the one to the right.
    // Masking the left column at col 0 and the right one at col W-1 stops the
    // previous/next row from leaking in across the wrap.
    assign w_rmask = {out_row_q == ROW_LAST, 1'b0, out_row_q == '0};
    assign w_lmask = (out_col_q == '0);
    assign w_cmask = (out_col_q == COL_LAST);

    always_comb begin
        w_win = '0;
        for (int i = 0; i < 3; i++) begin
            w_win[3*i]   = (w_rmask[i] || w_lmask) ? BORDER_VAL : cl_q[i];
            w_win[3*i+1] = w_rmask[i] ? BORDER_VAL : cc_q[i];
            w_win[3*i+2] = (w_rmask[i] || w_cmask) ? BORDER_VAL : w_in_col[i];
        end
    end

    always_comb begin
        case (op_q)
            OP_PASS:  w_res = cc_q[1];
            OP_ERODE: w_res = &w_win;
            OP_DIL:   w_res = |w_win;
            default:  w_res = (|w_win) ^ (&w_win);
        endcase
`ifdef MORPH_RANK_EN
        w_pop = '0;
        for (int i = 0; i < 9; i++) begin
            w_pop = w_pop + {3'b000, w_win[i]};
        end
        if (rank_q != '0) begin
            w_res = (w_pop >= rank_q);
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        in_col_d    = in_col_q;
        in_row_d    = in_row_q;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        op_d        = op_q;
        cl_d        = cl_q;
        cc_d        = cc_q;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        frame_err_d = w_stray || w_abort;
`ifdef MORPH_RANK_EN
        rank_d      = rank_q;
`endif

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (w_adv) begin
            cl_d = cc_q;
            cc_d = w_in_col;
            if (w_sof_start) begin
                in_col_d  = CW'(1);
                in_row_d  = '0;
                out_col_d = '0;
                out_row_d = '0;
                op_d      = op_i;
`ifdef MORPH_RANK_EN
                rank_d    = rank_k_i;
`endif
            end else if (in_col_q == COL_LAST) begin
                in_col_d = '0;
                in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + RW'(1);
            end else begin
                in_col_d = in_col_q + CW'(1);
            end
        end

        if (w_emit) begin
            out_valid_d = 1'b1;
            out_pixel_d = w_res;
            out_sof_d   = (out_col_q == '0) && (out_row_q == '0);
            out_eof_d   = (out_col_q == COL_LAST) && (out_row_q == ROW_LAST);
            if (out_col_q == COL_LAST) begin
                out_col_d = '0;
                out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + RW'(1);
            end else begin
                out_col_d = out_col_q + CW'(1);
            end
        end

        if (w_abort) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE:  if (w_sof_start) state_d = S_FILL;
            // Accept (1,0) is the W+1-th pixel; the next accept yields output 0.
            S_FILL:  if (w_abort) state_d = S_FILL;
                     else if (w_px_acc && (in_row_q == RW'(1)) && (in_col_q == '0))
                         state_d = S_RUN;
            S_RUN:   if (w_abort) state_d = S_FILL;
                     else if (w_px_acc && (in_row_q == ROW_LAST) && (in_col_q == COL_LAST))
                         state_d = S_FLUSH;
            S_FLUSH: if (out_valid_q && out_ready_i && out_eof_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            in_col_q    <= '0;
            in_row_q    <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            op_q        <= 2'b00;
            cl_q        <= '0;
            cc_q        <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef MORPH_RANK_EN
            rank_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_col_q    <= in_col_d;
            in_row_q    <= in_row_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            op_q        <= op_d;
            cl_q        <= cl_d;
            cc_q        <= cc_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            frame_err_q <= frame_err_d;
`ifdef MORPH_RANK_EN
            rank_q      <= rank_d;
`endif
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_pixel_o = out_pixel_q;
    assign out_sof_o   = out_valid_q && out_sof_q;
    assign out_eof_o   = out_valid_q && out_eof_q;
    assign busy_o      = (state_q != S_IDLE);
    assign frame_err_o = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_morph_stream_filter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_morph_stream_filter
// Description : Self-checking bench for morph_stream_filter (8x4 frames).
//               A window-rule model predicts every output beat; a monitor
//               compares each transferred beat against the expected queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morph_stream_filter;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam bit BV = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] op = 2'b00;
`ifdef MORPH_RANK_EN
    logic [3:0] rank_k = 4'd0;
`endif
    logic in_valid = 1'b0, in_pixel = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, out_pixel, out_sof, out_eof, busy, frame_err;

    morph_stream_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER_VAL(BV)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .op_i        (op),
`ifdef MORPH_RANK_EN
        .rank_k_i    (rank_k),
`endif
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_pixel_i  (in_pixel),
        .in_sof_i    (in_sof),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_pixel_o (out_pixel),
        .out_sof_o   (out_sof),
        .out_eof_o   (out_eof),
        .busy_o      (busy),
        .frame_err_o (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic pix; logic sof; logic eof;} beat_t;

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];
    beat_t rx_q[$];
    int    ready_mode = 0;
    bit    gap_mode = 1'b0;
    bit    stuck = 1'b0;

    function automatic void chk1(string nm, logic act, logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b required %b at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic void chkn(string nm, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
        end
    endfunction

    // Output pixel from the 3x3 neighbourhood rules, out-of-frame reads BV.
    function automatic bit model_px(input bit [N-1:0] fr, input int r, input int c,
                                    input bit [1:0] opv, input int rank);
        int ones;
        ones = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr;
                int cc;
                rr = r + dr;
                cc = c + dc;
                if (rr < 0 || rr >= H || cc < 0 || cc >= W) ones += int'(BV);
                else ones += int'(fr[rr*W+cc]);
            end
        end
        if (rank != 0) return ones >= rank;
        case (opv)
            2'd0:    return fr[r*W+c];
            2'd1:    return ones == 9;
            2'd2:    return ones > 0;
            default: return (ones > 0) != (ones == 9);
        endcase
    endfunction

    function automatic int model_ones(input bit [N-1:0] fr, input bit [1:0] opv, input int rank);
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += int'(model_px(fr, k / W, k % W, opv, rank));
        return s;
    endfunction

    function automatic void load_expected(input bit [N-1:0] fr, input bit [1:0] opv,
                                          input int rank, input int cnt);
        beat_t e;
        for (int k = 0; k < cnt; k++) begin
            e.pix = model_px(fr, k / W, k % W, opv, rank);
            e.sof = (k == 0);
            e.eof = (k == N - 1);
            exp_q.push_back(e);
        end
    endfunction

    function automatic int rx_ones();
        int s;
        s = 0;
        foreach (rx_q[i]) s += int'(rx_q[i].pix);
        return s;
    endfunction

    function automatic int rx_marks(input bit want_eof);
        int s;
        s = 0;
        foreach (rx_q[i]) s += want_eof ? int'(rx_q[i].eof) : int'(rx_q[i].sof);
        return s;
    endfunction

    // Output monitor: every transferred beat must match the model.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got pixel=%b sof=%b eof=%b required none at %0t",
                             out_pixel, out_sof, out_eof, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk1("out_pixel", out_pixel, e.pix);
                    chk1("out_sof", out_sof, e.sof);
                    chk1("out_eof", out_eof, e.eof);
                end
                rx_q.push_back({out_pixel, out_sof, out_eof});
            end
            if (busy && out_valid && !out_ready) chk1("in_ready_backpressure", in_ready, 1'b0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 55);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Present one pixel until accepted; returns aligned at posedge+2.
    task automatic push(input logic pix, input logic sof);
        int  n;
        bit  acc;
        n   = 0;
        acc = 1'b0;
        if (!stuck) begin
            if (gap_mode) repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
            in_valid = 1'b1;
            in_pixel = pix;
            in_sof   = sof;
            while (!acc && !stuck) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #2;
                n++;
                if (!acc && n > 500) begin
                    total++;
                    bad++;
                    stuck = 1'b1;
                    $display("FAIL push_timeout: got no accept in %0d cycles required accept", n);
                end
            end
            in_valid = 1'b0;
            in_sof   = 1'b0;
            in_pixel = 1'b0;
        end
    endtask

    task automatic set_cfg(input bit [1:0] opv, input int rank);
        op = opv;
`ifdef MORPH_RANK_EN
        rank_k = 4'(rank);
`endif
    endtask

    task automatic send_frame(input bit [N-1:0] fr, input bit [1:0] opv, input int rank);
        set_cfg(opv, rank);
        load_expected(fr, opv, rank, N);
        for (int i = 0; i < N; i++) push(fr[i], i == 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000 && !stuck) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got pending=%0d busy=%b required 0 and 0", exp_q.size(), busy);
        end
    endtask

    initial begin
        bit [N-1:0] fr, fr2;
        bit [1:0]   opv, opv2;
        int         rk;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_out_pixel", out_pixel, 1'b0);
        chk1("rst_out_sof", out_sof, 1'b0);
        chk1("rst_out_eof", out_eof, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_frame_err", frame_err, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // All-ones erode with first-output latency
        ready_mode = 0;
        gap_mode   = 1'b0;
        fr = '1;
        chkn("model_erode_ones", model_ones(fr, 2'd1, 0), 12);
        chkn("model_edge_ones", model_ones(fr, 2'd3, 0), 20);
        rx_q.delete();
        set_cfg(2'd1, 0);
        load_expected(fr, 2'd1, 0, N);
        for (int i = 0; i < N; i++) begin
            push(1'b1, i == 0);
            if (i == 8 || i == 9) begin
                @(negedge clk);
                chk1("first_valid_timing", out_valid, i == 9);
                @(posedge clk);
                #2;
            end
        end
        drain();
        chkn("t1_count", rx_q.size(), 32);
        chkn("t1_ones", rx_ones(), 12);
        chkn("t1_sof_count", rx_marks(1'b0), 1);
        chkn("t1_eof_count", rx_marks(1'b1), 1);
        if (rx_q.size() == 32) begin
            chk1("t1_sof_first", rx_q[0].sof, 1'b1);
            chk1("t1_eof_last", rx_q[31].eof, 1'b1);
            chk1("t1_px_r1c1", rx_q[9].pix, 1'b1);
            chk1("t1_px_r1c0", rx_q[8].pix, 1'b0);
        end

        // Single pixel dilate, no column wrap contamination
        rx_q.delete();
        fr = '0;
        fr[2*W+3] = 1'b1;
        send_frame(fr, 2'd2, 0);
        drain();
        chkn("t2_ones", rx_ones(), 9);
        if (rx_q.size() == 32) begin
            chk1("t2_px_r1c2", rx_q[1*W+2].pix, 1'b1);
            chk1("t2_px_r3c4", rx_q[3*W+4].pix, 1'b1);
            chk1("t2_px_r2c5", rx_q[2*W+5].pix, 1'b0);
            for (int r = 0; r < H; r++) begin
                chk1("t2_col0_clean", rx_q[r*W].pix, 1'b0);
                chk1("t2_col7_clean", rx_q[r*W+W-1].pix, 1'b0);
            end
        end

        // All-ones edge
        rx_q.delete();
        send_frame('1, 2'd3, 0);
        drain();
        chkn("t3_edge_ones", rx_ones(), 20);

        // All-ones erode under random backpressure
        ready_mode = 1;
        rx_q.delete();
        send_frame('1, 2'd1, 0);
        drain();
        chkn("t4_count", rx_q.size(), 32);
        chkn("t4_ones", rx_ones(), 12);

        // Random frames, ops, gaps and backpressure
        gap_mode = 1'b1;
        for (int f = 0; f < 20; f++) begin
            case ($urandom_range(0, 2))
                0:       fr = {$urandom, $urandom} & {$urandom, $urandom};
                1:       fr = {$urandom, $urandom};
                default: fr = {$urandom, $urandom} | {$urandom, $urandom};
            endcase
            opv = 2'($urandom_range(0, 3));
            rk  = 0;
`ifdef MORPH_RANK_EN
            if ($urandom_range(0, 2) == 0) rk = $urandom_range(1, 10);
`endif
            send_frame(fr, opv, rk);
            drain();
        end

        // In-frame SOF: abort at input 10, restart with a new frame
        rx_q.delete();
        fr   = {$urandom, $urandom};
        fr2  = {$urandom, $urandom};
        opv  = 2'($urandom_range(0, 3));
        opv2 = 2'($urandom_range(0, 3));
        set_cfg(opv, 0);
        load_expected(fr, opv, 0, 10 - W - 1);
        for (int i = 0; i < 10; i++) push(fr[i], i == 0);
        set_cfg(opv2, 0);
        load_expected(fr2, opv2, 0, N);
        push(fr2[0], 1'b1);
        @(negedge clk);
        chk1("abort_err_pulse", frame_err, 1'b1);
        chk1("abort_busy", busy, 1'b1);
        @(negedge clk);
        chk1("abort_err_clear", frame_err, 1'b0);
        @(posedge clk);
        #2;
        for (int i = 1; i < N; i++) push(fr2[i], 1'b0);
        drain();
        chkn("abort_rx_count", rx_q.size(), 33);
        chkn("abort_eof_count", rx_marks(1'b1), 1);

        // Stray pixel in IDLE is dropped
        push(1'b1, 1'b0);
        @(negedge clk);
        chk1("stray_err_pulse", frame_err, 1'b1);
        chk1("stray_busy", busy, 1'b0);
        @(negedge clk);
        chk1("stray_err_clear", frame_err, 1'b0);
        @(posedge clk);
        #2;

        // Asynchronous reset mid-frame, then a clean frame
        ready_mode = 0;
        gap_mode   = 1'b0;
        fr = {$urandom, $urandom};
        send_frame_partial: begin
            set_cfg(2'd2, 0);
            load_expected(fr, 2'd2, 0, N);
            for (int i = 0; i < 20; i++) push(fr[i], i == 0);
        end
        chk1("pre_reset_valid", out_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_valid", out_valid, 1'b0);
        chk1("async_rst_busy", busy, 1'b0);
        chk1("async_rst_sof", out_sof, 1'b0);
        chk1("async_rst_pixel", out_pixel, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        ready_mode = 1;
        gap_mode   = 1'b1;
        rx_q.delete();
        fr = {$urandom, $urandom};
        send_frame(fr, 2'd3, 0);
        drain();
        chkn("post_reset_count", rx_q.size(), 32);

`ifdef MORPH_RANK_EN
        // Rank mode
        rx_q.delete();
        send_frame('1, 2'd0, 5);
        drain();
        chkn("rank5_ones", rx_ones(), 28);
        if (rx_q.size() == 32) begin
            chk1("rank5_corner", rx_q[0].pix, 1'b0);
            chk1("rank5_edge", rx_q[1].pix, 1'b1);
        end
        rx_q.delete();
        send_frame('1, 2'd2, 10);
        drain();
        chkn("rank10_ones", rx_ones(), 0);
`endif

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
